// File: rtl/hazard_pkg.sv
// Shared constants for the hazard controller: forward-select codes and the
// data-memory wait FSM encoding.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/hazard_ctrl_mc_mult.sv
// mult_busy_tracker: down counter covering the multiplier's HI/LO latency.
// A multiply is taken only when the counter is idle and memory is not stalling.
module mult_busy_tracker #(
    parameter int MULT_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic hold_i,
    output logic busy_o,
    output logic accept_o
);

    localparam int CW = $clog2(MULT_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The counter keeps running through memory stalls; only acceptance is held off.
    always_comb begin
        accept_o = start_i && (cnt_q == '0) && !hold_i;
        cnt_d    = cnt_q;
        if (accept_o) begin
            cnt_d = CW'(MULT_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller: forwarding, load-use/branch/HI-LO/structural stalls and a
// timed data-memory wait FSM. Define HAZARD_PERF_CNT_EN to build the stall counter.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int MULT_LAT = 4,
    parameter int MEM_TO   = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  rsD,
    input  logic [RA_W-1:0]  rtD,
    input  logic [RA_W-1:0]  rsE,
    input  logic [RA_W-1:0]  rtE,
    input  logic [RA_W-1:0]  rf_waE,
    input  logic [RA_W-1:0]  rf_waM,
    input  logic [RA_W-1:0]  rf_waW,
    input  logic             we_regE,
    input  logic             we_regM,
    input  logic             we_regW,
    input  logic             dm2regE,
    input  logic             dm2regM,
    input  logic             branchD,
    input  logic             mult_startE,
    input  logic             hilo_readD,
    input  logic             dm_reqM,
    input  logic             dm_ack,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             fordAD,
    output logic             fordBD,
    output logic [1:0]       fordAE,
    output logic [1:0]       fordBE,
    output logic             dm_issue,
    output logic             mult_busy,
    output logic             dm_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             dbg_mem_state_o,
    output logic             dbg_mult_accept_o
);

    localparam int              WCW     = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
    localparam bit              TO_EN   = (MEM_TO > 0);
    localparam logic [WCW-1:0]  TO_LAST = WCW'((MEM_TO > 0) ? MEM_TO - 1 : 0);

    mem_state_e     state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           timeout_q, timeout_d;
    logic           timeout_hit;
    logic           ms, lw, br, hl, st;
    logic           mult_accept;

    // Forwarding: register 0 never matches, M wins over W.
    always_comb begin
        fordAE = FWD_RF;
        if (we_regM && rf_waM != '0 && rf_waM == rsE) begin
            fordAE = FWD_M;
        end else if (we_regW && rf_waW != '0 && rf_waW == rsE) begin
            fordAE = FWD_W;
        end
        fordBE = FWD_RF;
        if (we_regM && rf_waM != '0 && rf_waM == rtE) begin
            fordBE = FWD_M;
        end else if (we_regW && rf_waW != '0 && rf_waW == rtE) begin
            fordBE = FWD_W;
        end
        fordAD = we_regM && rf_waM != '0 && rf_waM == rsD;
        fordBD = we_regM && rf_waM != '0 && rf_waM == rtD;
    end

    mult_busy_tracker #(
        .MULT_LAT (MULT_LAT)
    ) u_mult (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mult_startE),
        .hold_i   (ms),
        .busy_o   (mult_busy),
        .accept_o (mult_accept)
    );

    // Memory handshake: dm_reqM is the M-stage request (valid), dm_ack the
    // response (ready). An access completes in the cycle both are high; until
    // then the pipeline is frozen, and a timeout completes it in place of the ack.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        dm_issue    = 1'b0;
        timeout_hit = TO_EN && (state_q == MEM_WAIT) && (wcnt_q == TO_LAST);
        ms          = dm_reqM && !dm_ack && !timeout_hit;
        timeout_d   = timeout_q || timeout_hit;
        case (state_q)
            MEM_IDLE: begin
                dm_issue = dm_reqM;
                if (ms) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = '0;
                end
            end
            MEM_WAIT: begin
                wcnt_d = wcnt_q + WCW'(1);
                if (dm_ack || timeout_hit) begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MEM_IDLE;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        lw = dm2regE && rtE != '0 && (rtE == rsD || rtE == rtD);
        br = branchD &&
             ((we_regE && rf_waE != '0 && (rf_waE == rsD || rf_waE == rtD)) ||
              (dm2regM && rf_waM != '0 && (rf_waM == rsD || rf_waM == rtD)));
        hl = hilo_readD && (mult_busy || mult_startE);
        st = mult_startE && mult_busy;
    end

    // A memory stall freezes F..M and overrides every flush except FlushW.
    assign StallF = ms || lw || br || hl || st;
    assign StallD = StallF;
    assign StallE = ms || st;
    assign StallM = ms;
    assign FlushE = (lw || br || hl) && !st && !ms;
    assign FlushM = st && !ms;
    assign FlushW = ms;

    assign dm_timeout        = timeout_q;
    assign dbg_mem_state_o   = (state_q == MEM_WAIT);
    assign dbg_mult_accept_o = mult_accept;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: directed scenarios plus a randomized run checked
// against a timestamp-based reference model. Honors HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl_mc;

    localparam int RA_W     = 5;
    localparam int MULT_LAT = 4;
    localparam int MEM_TO   = 16;
    localparam int CNT_W    = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [RA_W-1:0] rsD, rtD, rsE, rtE, rf_waE, rf_waM, rf_waW;
    logic we_regE, we_regM, we_regW, dm2regE, dm2regM, branchD;
    logic mult_startE, hilo_readD, dm_reqM, dm_ack;
    logic StallF, StallD, StallE, StallM, FlushE, FlushM, FlushW;
    logic fordAD, fordBD, dm_issue, mult_busy, dm_timeout;
    logic [1:0] fordAE, fordBE;
    logic [CNT_W-1:0] stall_cnt;
    logic dbg_mem_state_o, dbg_mult_accept_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_mc #(
        .RA_W(RA_W), .MULT_LAT(MULT_LAT), .MEM_TO(MEM_TO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .rf_waE(rf_waE), .rf_waM(rf_waM), .rf_waW(rf_waW),
        .we_regE(we_regE), .we_regM(we_regM), .we_regW(we_regW),
        .dm2regE(dm2regE), .dm2regM(dm2regM), .branchD(branchD),
        .mult_startE(mult_startE), .hilo_readD(hilo_readD),
        .dm_reqM(dm_reqM), .dm_ack(dm_ack),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .fordAD(fordAD), .fordBD(fordBD), .fordAE(fordAE), .fordBE(fordBE),
        .dm_issue(dm_issue), .mult_busy(mult_busy), .dm_timeout(dm_timeout),
        .stall_cnt(stall_cnt),
        .dbg_mem_state_o(dbg_mem_state_o), .dbg_mult_accept_o(dbg_mult_accept_o)
    );

    // ---------------- reference model (cycle timestamps) ----------------
    int cyc;        // cycles since reset
    int acc_t;      // cycle the last multiply was accepted
    int req_start;  // cycle the outstanding memory access began, -1 when none
    bit to_m;
    int perf_m;

    logic m_busy, m_wait, m_hit, m_ms, m_issue, m_accept;
    logic m_lw, m_br, m_hl, m_st, m_stall;
    logic [13:0] exp_vec, out_vec;
    logic [1:0]  exp_fae, exp_fbe;
    int          exp_cnt;

    function automatic bit hits(input logic [RA_W-1:0] w, input logic [RA_W-1:0] a,
                                input logic [RA_W-1:0] b);
        return (w != 0) && (w == a || w == b);
    endfunction

    function automatic logic [1:0] fwd(input logic [RA_W-1:0] src,
                                       input logic wm, input logic [RA_W-1:0] am,
                                       input logic ww, input logic [RA_W-1:0] aw);
        if (src != 0 && wm && src == am) return 2'b10;
        if (src != 0 && ww && src == aw) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        m_busy   = (cyc - acc_t >= 1) && (cyc - acc_t <= MULT_LAT);
        m_wait   = (req_start >= 0);
        m_hit    = (MEM_TO != 0) && m_wait && (cyc - req_start == MEM_TO);
        m_ms     = dm_reqM && !dm_ack && !m_hit;
        m_issue  = dm_reqM && !m_wait;
        m_accept = mult_startE && !m_busy && !m_ms;
        m_lw     = dm2regE && hits(rtE, rsD, rsD) || dm2regE && hits(rtE, rtD, rtD);
        m_br     = branchD && ((we_regE && hits(rf_waE, rsD, rtD)) ||
                               (dm2regM && hits(rf_waM, rsD, rtD)));
        m_hl     = hilo_readD && (m_busy || mult_startE);
        m_st     = mult_startE && m_busy;
        m_stall  = m_ms || m_lw || m_br || m_hl || m_st;
        exp_vec  = {m_stall, m_stall, m_ms || m_st, m_ms,
                    (m_lw || m_br || m_hl) && !m_st && !m_ms, m_st && !m_ms, m_ms,
                    we_regM && rsD != 0 && rsD == rf_waM,
                    we_regM && rtD != 0 && rtD == rf_waM,
                    m_issue, m_busy, to_m, m_wait, m_accept};
        exp_fae  = fwd(rsE, we_regM, rf_waM, we_regW, rf_waW);
        exp_fbe  = fwd(rtE, we_regM, rf_waM, we_regW, rf_waW);
        exp_cnt  = PERF_EN ? perf_m : 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc       <= 0;
            acc_t     <= -1000;
            req_start <= -1;
            to_m      <= 1'b0;
            perf_m    <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_accept) acc_t <= cyc;
            if (!m_wait && m_ms) req_start <= cyc;
            else if (m_wait && (dm_ack || m_hit)) req_start <= -1;
            if (m_hit) to_m <= 1'b1;
            if (m_stall && perf_m < CNT_MAX) perf_m <= perf_m + 1;
        end
    end

    assign out_vec = {StallF, StallD, StallE, StallM, FlushE, FlushM, FlushW,
                      fordAD, fordBD, dm_issue, mult_busy, dm_timeout,
                      dbg_mem_state_o, dbg_mult_accept_o};

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        rf_waE = '0; rf_waM = '0; rf_waW = '0;
        we_regE = 0; we_regM = 0; we_regW = 0; dm2regE = 0; dm2regM = 0;
        branchD = 0; mult_startE = 0; hilo_readD = 0; dm_reqM = 0; dm_ack = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        #2;
        checks++;
        if ({mult_busy, dm_timeout, dbg_mem_state_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state got %b exp 000", {mult_busy, dm_timeout, dbg_mem_state_o});
        end
        checks++;
        if (stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt got %0d exp 0", stall_cnt);
        end
        checks++;
        if ({StallF, StallE, FlushE, FlushM, FlushW, dm_issue} !== 6'b0) begin
            errors++;
            $display("FAIL reset_idle_outs got %b exp 000000",
                     {StallF, StallE, FlushE, FlushM, FlushW, dm_issue});
        end
        rsE = 5'd5; rf_waM = 5'd5; we_regM = 1'b1;
        #1;
        checks++;
        if (fordAE !== 2'b10) begin
            errors++;
            $display("FAIL reset_comb_fwd got %b exp 10", fordAE);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_forwarding();
        do_reset();
        next_cycle();
        rsE = 5'd8; rtE = 5'd8; rf_waM = 5'd8; rf_waW = 5'd8; we_regM = 1; we_regW = 1;
        rsD = 5'd8;
        #1;
        checks++;
        if ({fordAE, fordBE, fordAD} !== 5'b10101) begin
            errors++;
            $display("FAIL fwd_m got %b exp 10101", {fordAE, fordBE, fordAD});
        end
        next_cycle();
        we_regM = 0;
        #1;
        checks++;
        if ({fordAE, fordAD} !== 3'b010) begin
            errors++;
            $display("FAIL fwd_w got %b exp 010", {fordAE, fordAD});
        end
        next_cycle();
        rsE = 5'd0;
        #1;
        checks++;
        if (fordAE !== 2'b00) begin
            errors++;
            $display("FAIL fwd_rf got %b exp 00", fordAE);
        end
        next_cycle();
        rf_waW = 5'd0; rf_waM = 5'd0; we_regM = 1; rsD = 5'd0; rtE = 5'd0;
        #1;
        checks++;
        if ({fordAE, fordBE, fordAD} !== 5'b00000) begin
            errors++;
            $display("FAIL fwd_reg0 got %b exp 00000", {fordAE, fordBE, fordAD});
        end
    endtask

    task automatic test_load_use_branch();
        do_reset();
        next_cycle();
        dm2regE = 1; rtE = 5'd3; rsD = 5'd3;
        #1;
        checks++;
        if ({StallF, StallD, FlushE, StallE} !== 4'b1110) begin
            errors++;
            $display("FAIL lw_stall got %b exp 1110", {StallF, StallD, FlushE, StallE});
        end
        next_cycle();
        rtE = 5'd0; rsD = 5'd0;
        #1;
        checks++;
        if ({StallF, FlushE} !== 2'b00) begin
            errors++;
            $display("FAIL lw_reg0 got %b exp 00", {StallF, FlushE});
        end
        next_cycle();
        clear_inputs();
        branchD = 1; rtD = 5'd4; we_regE = 1; rf_waE = 5'd4;
        #1;
        checks++;
        if ({StallD, FlushE, StallE} !== 3'b110) begin
            errors++;
            $display("FAIL br_e got %b exp 110", {StallD, FlushE, StallE});
        end
        next_cycle();
        we_regE = 0; dm2regM = 1; rf_waM = 5'd4;
        #1;
        checks++;
        if ({StallD, FlushE} !== 2'b11) begin
            errors++;
            $display("FAIL br_m got %b exp 11", {StallD, FlushE});
        end
        next_cycle();
        dm2regM = 0;
        #1;
        checks++;
        if (StallD !== 1'b0) begin
            errors++;
            $display("FAIL br_none got %b exp 0", StallD);
        end
    endtask

    task automatic test_multiplier();
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            next_cycle();
            mult_startE = (c == 0);
            hilo_readD  = 1;
            @(negedge clk);
            checks++;
            if ({StallD, mult_busy, dbg_mult_accept_o} !== {c <= 4, c >= 1 && c <= 4, c == 0}) begin
                errors++;
                $display("FAIL mult_hilo c%0d got %b exp %b", c, {StallD, mult_busy, dbg_mult_accept_o},
                         {c <= 4, c >= 1 && c <= 4, c == 0});
            end
        end
        for (int c = 0; c <= 2; c++) begin
            next_cycle();
            hilo_readD  = 0;
            mult_startE = (c != 1);
            @(negedge clk);
            checks++;
            if ({StallE, FlushM, StallF, FlushE} !== {c == 2, c == 2, c == 2, 1'b0}) begin
                errors++;
                $display("FAIL mult_struct c%0d got %b exp %b", c, {StallE, FlushM, StallF, FlushE},
                         {c == 2, c == 2, c == 2, 1'b0});
            end
        end
    endtask

    task automatic test_memory_wait();
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            dm2regE = (c <= 3); rtE = 5'd3; rsD = 5'd3;
            dm_reqM = (c <= 3) || c == 5 || c == 7;
            dm_ack  = (c == 3) || c == 5 || c == 6 || c == 8;
            @(negedge clk);
            checks++;
            if ({dm_issue, StallM, FlushW, dbg_mem_state_o} !==
                {c == 0 || c == 5 || c == 7, c < 3 || c == 7, c < 3 || c == 7,
                 (c >= 1 && c <= 3) || c == 8}) begin
                errors++;
                $display("FAIL mem_wait c%0d got %b exp %b", c,
                         {dm_issue, StallM, FlushW, dbg_mem_state_o},
                         {c == 0 || c == 5 || c == 7, c < 3 || c == 7, c < 3 || c == 7,
                          (c >= 1 && c <= 3) || c == 8});
            end
            if (c < 3) begin
                checks++;
                if ({FlushE, StallF, StallE} !== 3'b011) begin
                    errors++;
                    $display("FAIL mem_noflush c%0d got %b exp 011", c, {FlushE, StallF, StallE});
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            next_cycle();
            dm_reqM     = (c <= 16) || (c >= 20);
            mult_startE = (c == 19);
            @(negedge clk);
            checks++;
            if ({StallM, dm_issue, dm_timeout, dbg_mem_state_o} !==
                {c < 16 || c >= 20, c == 0 || c == 20, c >= 17,
                 (c >= 1 && c <= 16) || c >= 21}) begin
                errors++;
                $display("FAIL timeout c%0d got %b exp %b", c,
                         {StallM, dm_issue, dm_timeout, dbg_mem_state_o},
                         {c < 16 || c >= 20, c == 0 || c == 20, c >= 17,
                          (c >= 1 && c <= 16) || c >= 21});
            end
        end
        checks++;
        if (mult_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst_busy got %b exp 1", mult_busy);
        end
        #2;
        rst = 1'b1;
        dm_reqM = 0; mult_startE = 0;
        #1;
        checks++;
        if ({dbg_mem_state_o, dm_timeout, mult_busy, StallM} !== 4'b0000) begin
            errors++;
            $display("FAIL async_rst got %b exp 0000", {dbg_mem_state_o, dm_timeout, mult_busy, StallM});
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({dm_issue, dbg_mem_state_o, dm_timeout} !== 3'b000) begin
            errors++;
            $display("FAIL post_rst got %b exp 000", {dm_issue, dbg_mem_state_o, dm_timeout});
        end
    endtask

    task automatic test_perf_counter();
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            next_cycle();
            dm2regE = (c < 10); rtE = 5'd7; rtD = 5'd7;
            @(negedge clk);
            if (c >= 10) begin
                checks++;
                if (stall_cnt !== CNT_W'(PERF_EN ? 10 : 0)) begin
                    errors++;
                    $display("FAIL perf_cnt c%0d got %0d exp %0d", c, stall_cnt, PERF_EN ? 10 : 0);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            next_cycle();
            rsD = RA_W'($urandom_range(0, 3)); rtD = RA_W'($urandom_range(0, 3));
            rsE = RA_W'($urandom_range(0, 3)); rtE = RA_W'($urandom_range(0, 3));
            rf_waE = RA_W'($urandom_range(0, 3)); rf_waM = RA_W'($urandom_range(0, 3));
            rf_waW = RA_W'($urandom_range(0, 3));
            we_regE = 1'($urandom_range(0, 1)); we_regM = 1'($urandom_range(0, 1));
            we_regW = 1'($urandom_range(0, 1));
            dm2regE = ($urandom_range(0, 3) == 0); dm2regM = ($urandom_range(0, 3) == 0);
            branchD = ($urandom_range(0, 3) == 0);
            mult_startE = ($urandom_range(0, 4) == 0);
            hilo_readD  = ($urandom_range(0, 3) == 0);
            if (i < 400) begin
                dm_reqM = ($urandom_range(0, 2) == 0);
                dm_ack  = ($urandom_range(0, 2) == 0);
            end else begin
                dm_reqM = ($urandom_range(0, 5) != 0);
                dm_ack  = ($urandom_range(0, 11) == 0);
            end
            @(negedge clk);
            checks++;
            if (out_vec !== exp_vec) begin
                errors++;
                $display("FAIL rand_ctrl i%0d got %b exp %b", i, out_vec, exp_vec);
            end
            checks++;
            if ({fordAE, fordBE} !== {exp_fae, exp_fbe}) begin
                errors++;
                $display("FAIL rand_fwd i%0d got %b exp %b", i, {fordAE, fordBE}, {exp_fae, exp_fbe});
            end
            checks++;
            if (stall_cnt !== CNT_W'(exp_cnt)) begin
                errors++;
                $display("FAIL rand_cnt i%0d got %0d exp %0d", i, stall_cnt, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use_branch();
        test_multiplier();
        test_memory_wait();
        test_timeout();
        test_perf_counter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Multi-cycle-aware hazard controller for the pipelined MIPS core, replacing the purely combinational hazard logic. It keeps the standard forwarding, load-use and branch stalls, and adds three things: parametrised register-address width, a tracker for a multi-cycle multiplier's HI/LO result, and a variable-latency data-memory handshake with a timeout. It sits beside the datapath and drives every stall, flush and forward select.

## Interface
- RA_W, 5: register address width
- MULT_LAT, 4: multiplier latency in cycles, minimum 1
- MEM_TO, 16: memory-wait timeout in cycles; 0 disables the timeout
- CNT_W, 16: stall-counter width
- Clock is `clk` and reset is `rst`; one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rsD, rtD, rsE, rtE  in  RA_W  source registers in the D and E stages
- rf_waE, rf_waM, rf_waW  in  RA_W  destination registers in the E, M and W stages
- we_regE, we_regM, we_regW  in  1  register write enables
- dm2regE, dm2regM  in  1  load in the E or M stage
- branchD  in  1  branch in the D stage
- mult_startE  in  1  multiply in the E stage
- hilo_readD  in  1  mfhi or mflo in the D stage
- dm_reqM  in  1  load or store in the M stage
- dm_ack  in  1  memory response this cycle
- StallF, StallD, StallE, StallM  out  1  stage hold
- FlushE, FlushM, FlushW  out  1  bubble insert
- fordAD, fordBD  out  1  forward the M result into D for the branch compare
- fordAE, fordBE  out  2  E-stage forward select: 00 register file, 01 W, 10 M
- dm_issue  out  1  one-cycle memory request strobe
- mult_busy  out  1  multiplier result pending
- dm_timeout  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  stall-cycle counter

## Operation
- **Forwarding**
  - Combinational.
  - Register 0 never matches.
  - M has priority over W.
  - fordAD/fordBD match the D source against rf_waM when we_regM is high.
- **Load-use stall (lw)**: dm2regE high, and rtE is nonzero and equals rsD or rtD.
- **Branch stall (br)**: raised when branchD is high and either condition holds, with register 0 excluded:
  - we_regE is high and rf_waE equals rsD or rtD;
  - dm2regM is high and rf_waM equals rsD or rtD.
- **Multiplier tracker**
  - Down counter; mult_busy is high whenever the counter is nonzero.
  - A multiply is accepted when mult_startE is high, the counter is 0 and there is no memory stall. Acceptance loads the counter with MULT_LAT.
  - The counter decrements every cycle, including during memory stalls.
  - HI/LO stall (hl) = hilo_readD and (mult_busy or mult_startE).
  - Structural stall (st) = mult_startE and mult_busy.
- **Memory FSM**, states MEM_IDLE and MEM_WAIT
  - dm_issue = dm_reqM in MEM_IDLE.
  - Memory stall (ms) = dm_reqM and not dm_ack and not timeout-hit.
  - MEM_IDLE goes to MEM_WAIT when ms is high.
  - MEM_WAIT goes to MEM_IDLE on dm_ack or timeout-hit.
  - The wait counter clears on entry to MEM_WAIT and increments in MEM_WAIT.
  - timeout-hit = MEM_TO nonzero, state MEM_WAIT and counter equal to MEM_TO−1.
  - timeout-hit sets dm_timeout and acts as the ack.
- **Output equations**
  - StallF = StallD = ms or lw or br or hl or st.
  - StallE = ms or st.
  - StallM = ms.
  - FlushE = (lw or br or hl) and not st and not ms.
  - FlushM = st and not ms.
  - FlushW = ms.
- **Priority**
  - A memory stall freezes the F, D, E and M stages and suppresses every other flush.
  - st suppresses FlushE.

## Timing
- **Reset values**
  - FSM in MEM_IDLE; both counters 0.
  - dm_timeout = 0; stall_cnt = 0; mult_busy = 0.
  - Combinational outputs follow their inputs.
- **Reset mid-operation**: an outstanding wait or busy count is abandoned. No dm_issue is re-sent until dm_reqM is seen again in MEM_IDLE.
- **Multiplier**: a multiply accepted in cycle t holds mult_busy high for cycles t+1 to t+MULT_LAT. An mfhi in D is released in cycle t+MULT_LAT+1.
- **Memory ack in the request cycle** (dm_ack in cycle t): no stall, and the state stays MEM_IDLE.
- **Late memory ack**: if the ack arrives in cycle t+k, the stall spans cycles t to t+k−1. The stall drops combinationally in cycle t+k, and the state returns to MEM_IDLE in t+k+1.
- **dm_issue**: exactly one pulse per access, because it is never asserted in MEM_WAIT.
- **dm_ack in MEM_IDLE** without dm_reqM is ignored.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments in every cycle with StallF high.
  - It saturates at all ones.
  - It clears on reset only.
- HAZARD_PERF_CNT_EN undefined:
  - stall_cnt is tied to 0 and no counter flops are built.
  - The port remains present.

## Structure
- **Shared package hazard_pkg**
  - Forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - Memory FSM state encoding.
- **Sub-module mult_busy_tracker**
  - Owns the multiplier down counter.
  - Outputs mult_busy and the accept signal.

## Test plan
- **Forwarding**
  - Setup: rsE=rf_waM=rf_waW=5'd8, we_regM=we_regW=1.
  - Expected: fordAE=10.
  - Then we_regM=0 → fordAE=01. Then rsE=0 → fordAE=00.
- **Load-use**
  - Setup: dm2regE=1, rtE=rsD=5'd3.
  - Expected: StallF=StallD=FlushE=1, StallE=0.
  - Then rtE=0 → no stall.
- **Multiplier**
  - Setup: MULT_LAT=4, mult_startE in cycle 0, hilo_readD held high.
  - Expected: StallD high in cycles 0–4 and low in cycle 5. A second mult_startE in cycle 2 gives StallE=FlushM=1.
- **Memory wait**
  - Setup: dm_reqM held high, dm_ack in cycle 3.
  - Expected: dm_issue pulses only in cycle 0. StallM=FlushW=1 in cycles 0–2. FlushE=0 throughout, even with lw active. The state is MEM_IDLE in cycle 4.
- **Timeout**
  - Setup: MEM_TO=16, dm_ack never asserted.
  - Expected: the stall releases in cycle 16 and dm_timeout rises in cycle 17 and stays high. An asynchronous rst asserted mid-wait clears the state and dm_timeout immediately.
- **Performance counter (HAZARD_PERF_CNT_EN)**
  - Setup: 10 stall cycles.
  - Expected: stall_cnt=10. With CNT_W=4 and 20 stall cycles, stall_cnt=15.
